apb_timer_unit: RTL and testbench

APB_TIMER_UNIT -- requirements
Module: apb_timer_unit

---
 rtl/apb_timer_pkg.sv | 18 +
 rtl/apb_timer_prescaler.sv | 33 +++
 rtl/apb_timer_unit.sv | 144 ++++++++++++++
 tb/tb_apb_timer_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_timer_pkg.sv
// Shared register map and field positions for the APB compare timer.
package apb_timer_pkg;

    localparam int unsigned PRESCALE_W = 8;

    localparam logic [3:0] OFS_CTRL   = 4'h0;
    localparam logic [3:0] OFS_COUNT  = 4'h4;
    localparam logic [3:0] OFS_CMP    = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
    localparam int unsigned CTRL_ONESHOT_BIT  = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;

    localparam int unsigned STATUS_MATCH_BIT = 0;

endpackage

// File: rtl/apb_timer_prescaler.sv
// Divides the clock into a one-cycle tick every prescale+1 cycles while enabled.
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    // A CTRL write restarts the division period and suppresses the tick.
    always_comb begin
        tick  = en & ~clr & (cnt_q == prescale);
        cnt_d = cnt_q + PRESCALE_W'(1);
        if (!en || clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_timer_unit.sv
// APB-mapped up-counter with compare match, W1C status, level irq and match event pulse.
module apb_timer_unit
    import apb_timer_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      irq_o,
    output logic                      event_o
);

    logic                  en_q, en_d;
    logic                  irq_en_q, irq_en_d;
    logic                  oneshot_q, oneshot_d;
    logic                  match_q, match_d;
    logic                  irq_q, irq_d;
    logic                  event_q, event_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  cmp_q, cmp_d;

    logic       addr_err_c;
    logic       wr_c;
    logic       ctrl_wr_c;
    logic       tick_c;
    logic [3:0] ofs_c;
    logic       unused_c;

    // Byte-lane bits of the address carry no meaning for word registers.
    assign unused_c   = ^PADDR[1:0];
    assign ofs_c      = {PADDR[3:2], 2'b00};
    assign addr_err_c = |PADDR[APB_ADDR_WIDTH-1:4];
    assign wr_c       = PSEL & PENABLE & PWRITE & ~addr_err_c;
    assign ctrl_wr_c  = wr_c & (ofs_c == OFS_CTRL);

    apb_timer_prescaler u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en       (en_q),
        .clr      (ctrl_wr_c),
        .prescale (prescale_q),
        .tick     (tick_c)
    );

    // Later assignments take priority: match beats W1C, COUNT write beats tick.
    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        oneshot_d  = oneshot_q;
        prescale_d = prescale_q;
        match_d    = match_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        event_d    = 1'b0;

        if (ctrl_wr_c) begin
            en_d       = PWDATA[CTRL_EN_BIT];
            irq_en_d   = PWDATA[CTRL_IRQ_EN_BIT];
            oneshot_d  = PWDATA[CTRL_ONESHOT_BIT];
            prescale_d = PWDATA[CTRL_PRESCALE_LSB +: PRESCALE_W];
        end
        if (wr_c && (ofs_c == OFS_CMP)) begin
            cmp_d = CNT_WIDTH'(PWDATA);
        end
        if (wr_c && (ofs_c == OFS_STATUS) && PWDATA[STATUS_MATCH_BIT]) begin
            match_d = 1'b0;
        end
        if (tick_c) begin
            if (count_q == cmp_q) begin
                count_d = '0;
                match_d = 1'b1;
                event_d = 1'b1;
                if (oneshot_q) begin
                    en_d = 1'b0;
                end
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
        if (wr_c && (ofs_c == OFS_COUNT)) begin
            count_d = CNT_WIDTH'(PWDATA);
        end

        irq_d = match_d & irq_en_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            oneshot_q  <= 1'b0;
            prescale_q <= '0;
            match_q    <= 1'b0;
            count_q    <= '0;
            cmp_q      <= '1;
            irq_q      <= 1'b0;
            event_q    <= 1'b0;
        end else begin
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            oneshot_q  <= oneshot_d;
            prescale_q <= prescale_d;
            match_q    <= match_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            irq_q      <= irq_d;
            event_q    <= event_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (!rst_i && PSEL && !PWRITE && !addr_err_c) begin
            case (ofs_c)
                OFS_CTRL: begin
                    PRDATA[CTRL_EN_BIT]                          = en_q;
                    PRDATA[CTRL_IRQ_EN_BIT]                      = irq_en_q;
                    PRDATA[CTRL_ONESHOT_BIT]                     = oneshot_q;
                    PRDATA[CTRL_PRESCALE_LSB +: PRESCALE_W]      = prescale_q;
                end
                OFS_COUNT:  PRDATA = 32'(count_q);
                OFS_CMP:    PRDATA = 32'(cmp_q);
                OFS_STATUS: PRDATA[STATUS_MATCH_BIT] = match_q;
                default:    PRDATA = '0;
            endcase
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = ~rst_i & PSEL & PENABLE & addr_err_c;
    assign irq_o   = irq_q;
    assign event_o = event_q;

endmodule

// File: tb/tb_apb_timer_unit.sv
// Self-checking bench for apb_timer_unit: register table, directed timing sequences, random traffic vs model.
module tb_apb_timer_unit;

    logic        clk_i;
    logic        rst_i;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        irq_o;
    logic        event_o;

    int errors;
    int checks;

    apb_timer_unit #(.APB_ADDR_WIDTH(12), .CNT_WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .irq_o   (irq_o),
        .event_o (event_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents plus cycles elapsed in the current tick period.
    logic        m_en, m_irq_en, m_oneshot, m_match, m_irq, m_event;
    logic [7:0]  m_pre;
    int unsigned m_phase;
    logic [31:0] m_count, m_cmp;
    logic        m_wr, m_ctrl_wr, m_tick;
    logic [1:0]  m_reg;

    function automatic logic [31:0] m_read(input logic [1:0] r);
        case (r)
            2'd0:    return {16'h0, m_pre, 5'h0, m_oneshot, m_irq_en, m_en};
            2'd1:    return m_count;
            2'd2:    return m_cmp;
            default: return {31'h0, m_match};
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_en = 0; m_irq_en = 0; m_oneshot = 0; m_pre = 0; m_phase = 0;
                m_count = 0; m_cmp = 32'hFFFF_FFFF; m_match = 0; m_irq = 0; m_event = 0;
            end else begin
                m_reg     = PADDR[3:2];
                m_wr      = PSEL && PENABLE && PWRITE && (PADDR[11:4] == 8'h0);
                m_ctrl_wr = m_wr && (m_reg == 2'd0);
                m_tick    = m_en && !m_ctrl_wr && (m_phase == 32'(m_pre));
                m_event   = 0;
                if (!m_en || m_ctrl_wr || m_tick) m_phase = 0;
                else m_phase = m_phase + 1;
                if (m_wr && m_reg == 2'd3 && PWDATA[0]) m_match = 0;
                if (m_tick) begin
                    if (m_count == m_cmp) begin
                        m_count = 0; m_match = 1; m_event = 1;
                        if (m_oneshot) m_en = 0;
                    end else begin
                        m_count = m_count + 1;
                    end
                end
                if (m_wr) begin
                    case (m_reg)
                        2'd0: begin
                            m_en = PWDATA[0]; m_irq_en = PWDATA[1];
                            m_oneshot = PWDATA[2]; m_pre = PWDATA[15:8];
                        end
                        2'd1: m_count = PWDATA;
                        2'd2: m_cmp = PWDATA;
                        default: ;
                    endcase
                end
                m_irq = m_match && m_irq_en;
            end
        end
    end

    // Every cycle: bus outputs and interrupt/event against the model.
    logic [31:0] exp_rd;
    logic        bad_addr;
    initial begin
        forever begin
            @(negedge clk_i);
            bad_addr = (PADDR[11:4] != 8'h0);
            exp_rd = 32'h0;
            if (!rst_i && PSEL && !PWRITE && !bad_addr) exp_rd = m_read(PADDR[3:2]);
            chk("mon_prdata", PRDATA, exp_rd);
            chk("mon_pslverr", 32'(PSLVERR), 32'(!rst_i && PSEL && PENABLE && bad_addr));
            chk("mon_pready", 32'(PREADY), 32'h1);
            chk("mon_irq", 32'(irq_o), 32'(m_irq));
            chk("mon_event", 32'(event_o), 32'(m_event));
        end
    end

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        @(posedge clk_i); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge clk_i); #1;
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge clk_i); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b1, addr, wdata, d, e);
    endtask

    task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string nm);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b0, addr, 32'h0, d, e);
        chk(nm, d, exp);
        chk({nm, "_err"}, 32'(e), 32'h0);
    endtask

    // Hold a read select so PRDATA follows a register cycle by cycle.
    task automatic watch(input logic [11:0] addr);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] rdata;
    logic        err;
    int          ev_cnt;
    int unsigned op;
    logic [31:0] rnd;
    logic [11:0] raddr;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        errors = 0; checks = 0;
        rst_i = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Register access table (timer stopped throughout)
        vecs.push_back('{1'b0, 12'h000, 32'h0,          32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h004, 32'h0,          32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h008, 32'h0,          32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{1'b0, 12'h00C, 32'h0,          32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h008, 32'h0000_1234,  32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h00B, 32'h0,          32'h0000_1234, 1'b0});
        vecs.push_back('{1'b1, 12'h000, 32'hFFFF_FF06,  32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h000, 32'h0,          32'h0000_FF06, 1'b0});
        vecs.push_back('{1'b1, 12'h005, 32'hDEAD_BEEF,  32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h004, 32'h0,          32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 12'h010, 32'hFFFF_FFFF,  32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 12'h008, 32'h0,          32'h0000_1234, 1'b0});
        vecs.push_back('{1'b0, 12'h000, 32'h0,          32'h0000_FF06, 1'b0});
        vecs.push_back('{1'b0, 12'h004, 32'h0,          32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 12'h010, 32'h0,          32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 12'h00C, 32'h0000_0001,  32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h00C, 32'h0,          32'h0000_0000, 1'b0});
        vecs.push_back('{1'b1, 12'h000, 32'h0000_0000,  32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 12'h000, 32'h0,          32'h0000_0000, 1'b0});
        foreach (vecs[i]) begin
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, err);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Free-run: CMP=5, period of 6 ticks
        wr(12'h008, 32'd5);
        wr(12'h004, 32'd0);
        wr(12'h000, 32'h3);
        watch(12'h004);
        chk("free_count0", PRDATA, 32'd0);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk_i); #2;
            chk($sformatf("free_count%0d", k), PRDATA, 32'(k % 6));
            chk($sformatf("free_event%0d", k), 32'(event_o), 32'(k % 6 == 0));
            chk($sformatf("free_irq%0d", k), 32'(irq_o), 32'(k >= 6));
        end
        PSEL = 1'b0;

        // Prescale 3: one increment per 4 cycles
        wr(12'h000, 32'h0);
        wr(12'h004, 32'd0);
        wr(12'h008, 32'd100);
        wr(12'h000, 32'h0301);
        watch(12'h004);
        chk("pre_count0", PRDATA, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk_i); #2;
            chk($sformatf("pre_count%0d", k), PRDATA, 32'(k / 4));
        end
        PSEL = 1'b0;

        // Oneshot: single match then en clears
        wr(12'h000, 32'h0);
        wr(12'h00C, 32'h1);
        wr(12'h004, 32'd0);
        wr(12'h008, 32'd2);
        wr(12'h000, 32'h7);
        watch(12'h000);
        chk("one_ctrl0", PRDATA, 32'h7);
        ev_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk_i); #2;
            if (event_o) ev_cnt++;
            chk($sformatf("one_ctrl%0d", k), PRDATA, (k >= 3) ? 32'h6 : 32'h7);
        end
        PSEL = 1'b0;
        chk("one_events", 32'(ev_cnt), 32'd1);
        rd(12'h004, 32'd0, "one_count");
        rd(12'h00C, 32'd1, "one_status");

        // Match in the same cycle as a STATUS W1C: match wins
        wr(12'h004, 32'd0);
        wr(12'h008, 32'd3);
        wr(12'h000, 32'h3);
        @(posedge clk_i);
        wr(12'h00C, 32'h1);
        chk("w1c_coll_event", 32'(event_o), 32'h1);
        watch(12'h00C);
        chk("w1c_coll_status", PRDATA, 32'h1);
        PSEL = 1'b0;
        wr(12'h000, 32'h0);
        wr(12'h00C, 32'h1);
        rd(12'h00C, 32'h0, "w1c_plain_status");

        // COUNT write in a tick cycle: written value kept
        wr(12'h008, 32'hFFFF_FFFF);
        wr(12'h004, 32'h50);
        wr(12'h000, 32'h1);
        wr(12'h004, 32'h100);
        watch(12'h004);
        chk("cnt_coll0", PRDATA, 32'h100);
        @(posedge clk_i); #2;
        chk("cnt_coll1", PRDATA, 32'h101);
        PSEL = 1'b0;

        // Reset pulsed mid-count with irq active and a write in flight
        wr(12'h000, 32'h0);
        wr(12'h004, 32'd0);
        wr(12'h008, 32'd1);
        wr(12'h000, 32'h3);
        repeat (5) @(posedge clk_i);
        #1;
        chk("rst_pre_irq", 32'(irq_o), 32'h1);
        rst_i = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'd5;
        #1;
        chk("rst_irq", 32'(irq_o), 32'h0);
        PWRITE = 1'b0; PADDR = 12'h010;
        #1;
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_pslverr", 32'(PSLVERR), 32'h0);
        PWRITE = 1'b1; PADDR = 12'h008;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h000;
        #1; chk("rst_ctrl", PRDATA, 32'h0);
        chk("rst_post_irq", 32'(irq_o), 32'h0);
        PADDR = 12'h004; #1; chk("rst_count", PRDATA, 32'h0);
        PADDR = 12'h008; #1; chk("rst_cmp", PRDATA, 32'hFFFF_FFFF);
        PADDR = 12'h00C; #1; chk("rst_status", PRDATA, 32'h0);
        PSEL = 1'b0;

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: repeat ($urandom_range(1, 8)) @(posedge clk_i);
                2: begin
                    rnd = ($urandom() & 32'hFFFF_00F8) | (32'($urandom_range(0, 3)) << 8)
                        | 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) rnd[0] = 1'b1;
                    wr(12'h000, rnd);
                end
                3: wr(12'h008, 32'($urandom_range(0, 15)));
                4: begin
                    if ($urandom_range(0, 9) == 0) wr(12'h004, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
                    else wr(12'h004, 32'($urandom_range(0, 15)));
                end
                5: wr(12'h00C, $urandom());
                6, 7: apb_xfer(1'b0, 12'($urandom_range(0, 15)), 32'h0, rdata, err);
                8: begin
                    raddr = 12'($urandom_range(1, 255) << 4) | 12'($urandom_range(0, 15));
                    apb_xfer(1'($urandom_range(0, 1)), raddr, $urandom(), rdata, err);
                    chk("rnd_err", 32'(err), 32'h1);
                end
                default: apb_xfer(1'b1, 12'($urandom_range(0, 15)), $urandom(), rdata, err);
            endcase
        end
        repeat (4) @(posedge clk_i);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
